// File: rtl/router_decap_controller.sv
// Receive-side decapsulation: pops one header+payload packet from the output-port-0 FIFO
// and writes the payload to local memory. Defining DECAP_PKT_STATS_EN adds saturating packet counters.
module router_decap_controller #(
    parameter int AURORA_DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH             = 10,
    parameter int NUMBER_PACKET          = 19,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_decap_pkt,
    output logic                         decap_done,
    output logic                         decap_err,
    output logic [8:0]                   header_pkt_recv,
    output logic [ADDR_WIDTH-1:0]        dst_addr_arbiter_recv,
    input  logic                         empty_output_port_0,
    output logic                         rd_output_port_0,
    input  logic [AURORA_DATA_WIDTH-1:0] data_port0_out,
    output logic                         arbiter_write_req,
    input  logic                         arbiter_write_gnt,
    output logic [ADDR_WIDTH-1:0]        arbiter_dst_addr,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [AURORA_DATA_WIDTH-1:0] mem_wdata
`ifdef DECAP_PKT_STATS_EN
    ,
    output logic [15:0]                  pkt_ok_cnt,
    output logic [15:0]                  pkt_drop_cnt
`endif
);

    localparam int         TTL_LSB = 5 + RECOGNIZE_ROUTER_WIDTH;
    localparam int         DST_LSB = TTL_LSB + 2;
    localparam logic [4:0] MAX_LEN = 5'(NUMBER_PACKET);

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        LATCH_HDR,
        ARB,
        XFER,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [4:0]              rem;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic                    rd_pending;

    logic [4:0]              hdr_len;
    logic [1:0]              hdr_ttl;
    logic [ADDR_WIDTH-1:0]   hdr_dst;
    logic                    hdr_bad;
    logic                    payload_strobe;

    assign hdr_len = data_port0_out[4:0];
    assign hdr_ttl = data_port0_out[TTL_LSB +: 2];
    assign hdr_dst = data_port0_out[DST_LSB +: ADDR_WIDTH];
    assign hdr_bad = (hdr_len == 5'd0) || (hdr_len > MAX_LEN);

    assign payload_strobe = rd_output_port_0 && ((state == XFER) || (state == DRAIN));

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next       = state;
        rd_output_port_0 = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_decap_pkt) state_next = RD_HDR;
            end
            RD_HDR: begin
                rd_output_port_0 = !empty_output_port_0;
                if (!empty_output_port_0) state_next = LATCH_HDR;
            end
            LATCH_HDR: begin
                if (hdr_bad)               state_next = DONE;
                else if (hdr_ttl == 2'd0)  state_next = DRAIN;
                else                       state_next = ARB;
            end
            ARB: begin
                if (arbiter_write_gnt) state_next = XFER;
            end
            XFER, DRAIN: begin
                rd_output_port_0 = !empty_output_port_0 && (rem != 5'd0);
                // Leave only once the last popped word has been consumed.
                if ((rem == 5'd0) && !rd_pending) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            rem                   <= '0;
            wptr                  <= '0;
            rd_pending            <= 1'b0;
            decap_done            <= 1'b0;
            decap_err             <= 1'b0;
            header_pkt_recv       <= '0;
            dst_addr_arbiter_recv <= '0;
            arbiter_write_req     <= 1'b0;
            arbiter_dst_addr      <= '0;
            mem_we                <= 1'b0;
            mem_addr              <= '0;
            mem_wdata             <= '0;
        end else begin
            state             <= state_next;
            decap_done        <= (state_next == DONE);
            decap_err         <= (state == LATCH_HDR) && (state_next == DONE);
            arbiter_write_req <= (state_next == ARB) || (state_next == XFER);
            rd_pending        <= payload_strobe;
            mem_we            <= rd_pending && (state == XFER);

            if (state == LATCH_HDR) begin
                header_pkt_recv       <= data_port0_out[8:0];
                dst_addr_arbiter_recv <= hdr_dst;
                rem                   <= hdr_len;
                wptr                  <= hdr_dst;
                if (state_next == ARB) arbiter_dst_addr <= hdr_dst;
            end else if (payload_strobe) begin
                rem <= rem - 5'd1;
            end

            // FIFO data is valid the cycle after its strobe; capture it then.
            if (rd_pending && (state == XFER)) begin
                mem_addr  <= wptr;
                mem_wdata <= data_port0_out;
                wptr      <= wptr + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef DECAP_PKT_STATS_EN
    logic pkt_ok_evt;
    logic pkt_drop_evt;

    assign pkt_ok_evt   = (state == XFER) && (state_next == DONE);
    assign pkt_drop_evt = ((state == DRAIN) || (state == LATCH_HDR)) && (state_next == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (pkt_ok_evt && (pkt_ok_cnt != 16'hFFFF))     pkt_ok_cnt   <= pkt_ok_cnt + 16'd1;
            if (pkt_drop_evt && (pkt_drop_cnt != 16'hFFFF)) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
        end
    end
`endif

endmodule
